dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
Two-requester arbiter and access sequencer for the 12 KB byte-addressed data memory (dm). It shares the memory's single port between the CPU load/store unit (m0) and a loader/DMA port (m1). Each access is a registered, fixed-latency transaction with a req/ack handshake, and the block range- and alignment-checks every access. It sits between the requesters and the dm instance and drives dm's addr/din/we/byteOp directly.

Parameters:
ADDR_W, 14, byte-address width of dm.
DATA_W, 32, data width.
DM_BYTES, 12288, memory size in bytes; sets the legal address range.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
m0_req  in  1  CPU request; held with operands stable until m0_ack
m0_addr  in  ADDR_W  CPU byte address
m0_wdata  in  DATA_W  CPU write data (byte ops use bits 7:0)
m0_we  in  1  1 = write, 0 = read
m0_byte  in  1  1 = byte access, 0 = word access
m0_ack  out  1  one-cycle completion pulse
m0_rdata  out  DATA_W  read data, valid while m0_ack=1
m0_err  out  1  access error, valid while m0_ack=1
m1_req, m1_addr, m1_wdata, m1_we, m1_byte, m1_ack, m1_rdata, m1_err: identical to m0 for the loader port
dm_addr  out  ADDR_W  to dm addr
dm_din  out  DATA_W  to dm din
dm_we  out  1  to dm we
dm_byteOp  out  1  to dm byteOp
dm_dout  in  DATA_W  from dm dout (combinational read)

Behaviour:
- Reset values: state IDLE; all acks, errs and rdata 0; dm_addr, dm_din and dm_byteOp 0; internal we_q 0; last_grant = m1, so m0 wins the first tie.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE: if any req is high, pick an owner. On the clock edge, latch the owner's addr/wdata/we/byte into the dm_* registers, latch err, then go to ACCESS. With no req, stay in IDLE.
- ACCESS: dm_* are driven from the latched registers.
  - dm_we = we_q & ~err_q & ~rst. It is combinationally gated, so a reset in this cycle suppresses the write.
  - At the end of the cycle, capture the owner's rdata: sign-extended byte or full word as returned by dm_dout. If err_q, capture 0.
  - Next state is RESP.
- RESP: the owner's ack = 1 for exactly one cycle, with rdata and err valid. dm_we = 0. Next state is IDLE.
- Latency and throughput: req sampled high in IDLE cycle N gives ack in cycle N+2. Maximum throughput is one transaction per 3 cycles.
- Handshake: the requester drops req or presents a new request in the cycle after ack. If req is high in IDLE, it is treated as a new transaction.
- Arbitration is 2-way round-robin:
  - With a single requester, that requester is granted.
  - With both requesting, the one not in last_grant is granted.
  - last_grant updates on the grant.
  - The non-owner's req is ignored until the state returns to IDLE; its ack stays 0.
- Error rules (err_q):
  - Word access with addr[1:0] != 0 is an error.
  - Word access with addr > DM_BYTES-4 is an error.
  - Byte access with addr > DM_BYTES-1 is an error.
  - An errored transaction never asserts dm_we, returns rdata = 0, and still completes with ack.
- Reset mid-operation: rst in ACCESS or RESP returns the FSM to IDLE on the next edge. No ack is issued, no write occurs, and last_grant is reset.
- dm_addr and dm_din hold their last value in IDLE. Only dm_we is qualified.

Decomposition:
- Package dm_arb_pkg holds:
  - the state encoding (IDLE/ACCESS/RESP);
  - requester IDs (M0=0, M1=1);
  - DM_BYTES and the word-size constant 4.
- Sub-module dm_rr_pick is the combinational 2-way round-robin picker. Inputs are req[1:0] and last_grant; outputs are grant_valid and grant_id.
- The FSM, operand registers and error check stay in dm_arbiter.

Test Plan:
1. m0 word write 0x0010 <- 0xDEADBEEF, then m0 word read 0x0010 -> each ack arrives 2 cycles after req; rdata = 0xDEADBEEF; err = 0.
2. m1 byte write 0x0013 <- 0x000000F0, then word read 0x0010 -> 0xF0ADBEEF; byte read 0x0013 -> 0xFFFFFFF0.
3. Both ports request from the first IDLE cycle N after reset and keep issuing back-to-back reads -> m0_ack at N+2, m1_ack at N+5, m0_ack at N+8; strict alternation, no ack while not owner.
4. Boundary accesses:
   - word 0x0011 -> err = 1, rdata = 0, memory unchanged;
   - word 0x2FFD -> err = 1;
   - word 0x2FFC -> ok;
   - byte 0x2FFF write 0x7F, read back 0x0000007F.
5. m0 word write 0x0020 <- 0x12345678, with rst asserted during its ACCESS cycle -> dm_we never high, no m0_ack; a later read of 0x0020 returns 0x00000000.
6. Only m1 requesting, 3 consecutive writes to 0x0100/0x0104/0x0108 -> all granted to m1, acks 3 cycles apart, m0_ack stays 0.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared definitions for the data-memory arbiter.
//   state_t    - access sequencer states (IDLE / ACCESS / RESP)
//   M0, M1     - requester IDs (CPU load/store unit, loader/DMA)
//   DM_BYTES   - data memory size in bytes (legal range 0 .. DM_BYTES-1)
//   WORD_BYTES - bytes per word access
package dm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int DM_BYTES   = 12288;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dm_rr_pick.sv
// dm_rr_pick: combinational 2-way round-robin picker.
//   req[1:0]    - request lines, bit index = requester ID
//   last_grant  - ID granted most recently
//   grant_valid - at least one request present
//   grant_id    - ID to grant this cycle
module dm_rr_pick
  import dm_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |req;
    // On a tie the requester that did not win last time goes next;
    // otherwise the lone requester wins.
    if (&req) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req[1] ? M1 : M0;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single port of the byte-addressed data memory
// between the CPU (m0) and the loader/DMA port (m1). Each access is a
// fixed three-state sequence IDLE -> ACCESS -> RESP, with a one-cycle ack
// to the owner, and is range/alignment checked before it touches memory.
//   clk, rst        - clock, synchronous active-high reset
//   mX_req/addr/wdata/we/byte - requester X operands (held until ack)
//   mX_ack/rdata/err          - one-cycle completion with read data/error
//   dm_addr/din/we/byteOp     - drive the dm instance
//   dm_dout                   - dm combinational read data
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int DM_BYTES = dm_arb_pkg::DM_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_we,
  input  logic              m0_byte,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_we,
  input  logic              m1_byte,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  output logic              dm_we,
  output logic              dm_byteOp,
  input  logic [DATA_W-1:0] dm_dout
);

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] din_reg;
  logic              we_reg;
  logic              byte_reg;
  logic              err_reg;
  logic              owner_reg;
  logic              last_grant_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic [1:0]        req_v;
  logic              grant_valid;
  logic              grant_id;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              sel_byte;
  logic [31:0]       sel_addr_ext;
  logic              err_next;
  logic              resp_fire;

  logic              ack_v   [2];
  logic [DATA_W-1:0] rdata_v [2];
  logic              err_v   [2];

  assign req_v = {m1_req, m0_req};

  dm_rr_pick u_pick (
    .req         (req_v),
    .last_grant  (last_grant_reg),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Operands of whichever requester the picker chose.
  assign sel_addr  = grant_id ? m1_addr  : m0_addr;
  assign sel_wdata = grant_id ? m1_wdata : m0_wdata;
  assign sel_we    = grant_id ? m1_we    : m0_we;
  assign sel_byte  = grant_id ? m1_byte  : m0_byte;

  assign sel_addr_ext = {{(32-ADDR_W){1'b0}}, sel_addr};

  always_comb begin
    if (sel_byte) begin
      err_next = (sel_addr_ext > 32'(DM_BYTES - 1));
    end else begin
      err_next = (sel_addr[1:0] != 2'b00) ||
                 (sel_addr_ext > 32'(DM_BYTES - WORD_BYTES));
    end
  end

  // State register plus operand/response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= '0;
      din_reg        <= '0;
      we_reg         <= 1'b0;
      byte_reg       <= 1'b0;
      err_reg        <= 1'b0;
      owner_reg      <= M0;
      last_grant_reg <= M1;
      rdata_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && grant_valid) begin
        addr_reg       <= sel_addr;
        din_reg        <= sel_wdata;
        we_reg         <= sel_we;
        byte_reg       <= sel_byte;
        err_reg        <= err_next;
        owner_reg      <= grant_id;
        last_grant_reg <= grant_id;
      end
      if (state_reg == ST_ACCESS) begin
        if (err_reg) begin
          rdata_reg <= '0;
        end else if (byte_reg) begin
          rdata_reg <= {{(DATA_W-8){dm_dout[7]}}, dm_dout[7:0]};
        end else begin
          rdata_reg <= dm_dout;
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (grant_valid) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output logic. rst gates dm_we and the response combinationally so a
  // reset landing in ACCESS/RESP neither writes memory nor acks.
  always_comb begin
    dm_we     = (state_reg == ST_ACCESS) & we_reg & ~err_reg & ~rst;
    resp_fire = (state_reg == ST_RESP) & ~rst;
  end

  assign dm_addr   = addr_reg;
  assign dm_din    = din_reg;
  assign dm_byteOp = byte_reg;

  // Per-requester response fan-out: only the owner sees ack/rdata/err.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      assign ack_v[gi]   = resp_fire && (owner_reg == 1'(gi));
      assign rdata_v[gi] = ack_v[gi] ? rdata_reg : '0;
      assign err_v[gi]   = ack_v[gi] & err_reg;
    end
  endgenerate

  assign m0_ack   = ack_v[0];
  assign m0_rdata = rdata_v[0];
  assign m0_err   = err_v[0];
  assign m1_ack   = ack_v[1];
  assign m1_rdata = rdata_v[1];
  assign m1_err   = err_v[1];

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter with a behavioural
// little-endian data memory hanging off the dm_* port.
module tb_dm_arbiter;

  localparam int MEM_BYTES = 12288;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_v  = '0;
  logic [1:0]  we_v   = '0;
  logic [1:0]  byte_v = '0;
  logic [13:0] addr_v  [2];
  logic [31:0] wdata_v [2];

  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [13:0] dm_addr;
  logic [31:0] dm_din, dm_dout;
  logic        dm_we, dm_byteOp;

  logic [7:0]  dm_mem  [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  exp_t        q0 [$];
  exp_t        q1 [$];

  int          err_cnt = 0;
  int          chk_cnt = 0;
  int          cyc = 0;
  int          dm_a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (req_v[0]),
    .m0_addr   (addr_v[0]),
    .m0_wdata  (wdata_v[0]),
    .m0_we     (we_v[0]),
    .m0_byte   (byte_v[0]),
    .m0_ack    (m0_ack),
    .m0_rdata  (m0_rdata),
    .m0_err    (m0_err),
    .m1_req    (req_v[1]),
    .m1_addr   (addr_v[1]),
    .m1_wdata  (wdata_v[1]),
    .m1_we     (we_v[1]),
    .m1_byte   (byte_v[1]),
    .m1_ack    (m1_ack),
    .m1_rdata  (m1_rdata),
    .m1_err    (m1_err),
    .dm_addr   (dm_addr),
    .dm_din    (dm_din),
    .dm_we     (dm_we),
    .dm_byteOp (dm_byteOp),
    .dm_dout   (dm_dout)
  );

  // Behavioural dm: combinational read, byte read zero-extended in [7:0].
  assign dm_a = int'(dm_addr);
  always_comb begin
    dm_dout = '0;
    if (dm_byteOp) begin
      if (dm_a < MEM_BYTES) dm_dout = {24'h0, dm_mem[dm_a]};
    end else if (dm_a + 3 < MEM_BYTES) begin
      dm_dout = {dm_mem[dm_a+3], dm_mem[dm_a+2], dm_mem[dm_a+1], dm_mem[dm_a]};
    end
  end

  always @(posedge clk) begin
    if (dm_we) begin
      if (dm_byteOp) begin
        if (dm_a < MEM_BYTES) dm_mem[dm_a] <= dm_din[7:0];
      end else if (dm_a + 3 < MEM_BYTES) begin
        dm_mem[dm_a]   <= dm_din[7:0];
        dm_mem[dm_a+1] <= dm_din[15:8];
        dm_mem[dm_a+2] <= dm_din[23:16];
        dm_mem[dm_a+3] <= dm_din[31:24];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response monitor: pops the owner's scoreboard on every ack.
  always @(negedge clk) begin
    exp_t e;
    if (m0_ack || m1_ack) check_eq("ack_exclusive", 32'(m0_ack & m1_ack), 32'd0);
    if (m0_ack) begin
      if (q0.size() == 0) begin
        check_eq("m0_unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        check_eq("m0_rdata", m0_rdata, e.rdata);
        check_eq("m0_err", 32'(m0_err), 32'(e.err));
        $display("txn m0 ack rdata=0x%08h err=%0d cycle=%0d", m0_rdata, m0_err, cyc);
      end
    end
    if (m1_ack) begin
      if (q1.size() == 0) begin
        check_eq("m1_unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        check_eq("m1_rdata", m1_rdata, e.rdata);
        check_eq("m1_err", 32'(m1_err), 32'(e.err));
        $display("txn m1 ack rdata=0x%08h err=%0d cycle=%0d", m1_rdata, m1_err, cyc);
      end
    end
  end

  // Issue one transaction on port p, push its expected response, wait for
  // the ack and check the latency, then release req in the following cycle.
  task automatic txn(input int p, input logic [13:0] a, input logic [31:0] wd,
                     input logic we, input logic byt, input int exp_lat,
                     output int ack_cyc);
    exp_t e;
    int   ai;
    int   n;
    logic got;
    ai = int'(a);
    if (byt) e.err = (ai > MEM_BYTES - 1);
    else     e.err = (a[1:0] != 2'b00) || (ai > MEM_BYTES - 4);
    if (e.err)    e.rdata = 32'h0;
    else if (byt) e.rdata = {{24{ref_mem[ai][7]}}, ref_mem[ai]};
    else          e.rdata = {ref_mem[ai+3], ref_mem[ai+2], ref_mem[ai+1], ref_mem[ai]};
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    if (we && !e.err) begin
      if (byt) ref_mem[ai] = wd[7:0];
      else begin
        ref_mem[ai]   = wd[7:0];
        ref_mem[ai+1] = wd[15:8];
        ref_mem[ai+2] = wd[23:16];
        ref_mem[ai+3] = wd[31:24];
      end
    end
    addr_v[p] = a; wdata_v[p] = wd; we_v[p] = we; byte_v[p] = byt; req_v[p] = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      got = (p == 0) ? m0_ack : m1_ack;
      if (got || n > 40) break;
      n++;
    end
    if (!got) check_eq("ack_timeout", 32'd1, 32'd0);
    else      check_eq("ack_latency", 32'(n), 32'(exp_lat));
    ack_cyc = cyc;
    @(posedge clk); #1;
    req_v[p] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int c1, c2, c3, d;
    for (int i = 0; i < MEM_BYTES; i++) begin
      dm_mem[i]  = 8'h00;
      ref_mem[i] = 8'h00;
    end
    for (int i = 0; i < 2; i++) begin
      addr_v[i]  = '0;
      wdata_v[i] = '0;
    end

    // Reset state
    do_reset();
    @(negedge clk);
    check_eq("rst_m0_ack", 32'(m0_ack), 32'd0);
    check_eq("rst_m1_ack", 32'(m1_ack), 32'd0);
    check_eq("rst_m0_rdata", m0_rdata, 32'd0);
    check_eq("rst_dm_addr", 32'(dm_addr), 32'd0);
    check_eq("rst_dm_din", dm_din, 32'd0);
    check_eq("rst_dm_we_byte", 32'({dm_we, dm_byteOp}), 32'd0);
    @(posedge clk); #1;

    // 1: m0 word write/read
    txn(0, 14'h0010, 32'hDEADBEEF, 1'b1, 1'b0, 2, c1);
    txn(0, 14'h0010, 32'h0, 1'b0, 1'b0, 2, c1);

    // 2: m1 byte write, word read, sign-extended byte read
    txn(1, 14'h0013, 32'h000000F0, 1'b1, 1'b1, 2, c1);
    txn(1, 14'h0010, 32'h0, 1'b0, 1'b0, 2, c1);
    txn(1, 14'h0013, 32'h0, 1'b0, 1'b1, 2, c1);

    // 3: both ports from the first IDLE cycle after reset, back-to-back reads
    do_reset();
    fork
      begin
        int c;
        txn(0, 14'h0010, 32'h0, 1'b0, 1'b0, 2, c);
        txn(0, 14'h0010, 32'h0, 1'b0, 1'b0, 5, c);
        txn(0, 14'h0010, 32'h0, 1'b0, 1'b0, 5, c);
      end
      begin
        int c;
        txn(1, 14'h0010, 32'h0, 1'b0, 1'b0, 5, c);
        txn(1, 14'h0012, 32'h0, 1'b0, 1'b1, 5, c);
      end
    join

    // 4: boundaries
    txn(0, 14'h0011, 32'h0, 1'b0, 1'b0, 2, c1);
    txn(0, 14'h0011, 32'h11111111, 1'b1, 1'b0, 2, c1);
    txn(0, 14'h0010, 32'h0, 1'b0, 1'b0, 2, c1);
    txn(0, 14'h2FFD, 32'h0, 1'b0, 1'b0, 2, c1);
    txn(0, 14'h2FFC, 32'hCAFEF00D, 1'b1, 1'b0, 2, c1);
    txn(0, 14'h2FFC, 32'h0, 1'b0, 1'b0, 2, c1);
    txn(1, 14'h2FFF, 32'h0000007F, 1'b1, 1'b1, 2, c1);
    txn(1, 14'h2FFF, 32'h0, 1'b0, 1'b1, 2, c1);
    txn(1, 14'h3000, 32'h0, 1'b0, 1'b1, 2, c1);

    // 5: reset during ACCESS of a write suppresses write and ack
    addr_v[0] = 14'h0020; wdata_v[0] = 32'h12345678; we_v[0] = 1'b1; byte_v[0] = 1'b0;
    req_v[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_access_dm_we", 32'(dm_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_v[0] = 1'b0;
    d = 0;
    repeat (4) begin
      @(negedge clk);
      if (m0_ack || dm_we) d++;
    end
    check_eq("rst_access_no_ack_we", 32'(d), 32'd0);
    @(posedge clk); #1;
    txn(0, 14'h0020, 32'h0, 1'b0, 1'b0, 2, c1);

    // 6: m1 only, three consecutive writes, acks 3 cycles apart
    txn(1, 14'h0100, 32'hA0A0A0A0, 1'b1, 1'b0, 2, c1);
    txn(1, 14'h0104, 32'hB1B1B1B1, 1'b1, 1'b0, 2, c2);
    txn(1, 14'h0108, 32'hC2C2C2C2, 1'b1, 1'b0, 2, c3);
    check_eq("m1_ack_spacing_a", 32'(c2 - c1), 32'd3);
    check_eq("m1_ack_spacing_b", 32'(c3 - c2), 32'd3);
    txn(1, 14'h0104, 32'h0, 1'b0, 1'b0, 2, c1);

    repeat (4) @(negedge clk);
    check_eq("scoreboard_empty", 32'(q0.size() + q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
